// File: rtl/buff_uart_bus_master_if.sv
// Bus and user-stream signals between buff_uart_bus_master (master) and
// its neighbours: the user byte stream and the buff_uart register bus.
interface buff_uart_bus_master_if #(
    parameter int width      = 8,
    parameter int addr_width = 8
);
    logic [width-1:0]      tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [width-1:0]      rx_data;
    logic                  rx_valid;
    logic [addr_width-1:0] active_address;
    logic                  read_enable;
    logic                  write_enable;
    logic [width-1:0]      bus_data_out;
    logic [width-1:0]      bus_data_in;

    modport master (
        input  tx_data, tx_valid, bus_data_in,
        output tx_ready, rx_data, rx_valid,
        output active_address, read_enable, write_enable, bus_data_out
    );

    modport slave (
        output tx_data, tx_valid, bus_data_in,
        input  tx_ready, rx_data, rx_valid,
        input  active_address, read_enable, write_enable, bus_data_out
    );
endinterface

// File: rtl/buff_uart_bus_master.sv
// Bus master for buff_uart: polls status, drains received bytes, pushes queued
// transmit bytes. Define BUFF_UART_BUS_MASTER_STATS_EN to add tx/rx counters.
module buff_uart_bus_master #(
    parameter int width          = 8,
    parameter int addr_width     = 8,
    parameter int rx_address     = 3,
    parameter int tx_address     = 4,
    parameter int status_address = 5,
    parameter int fifo_depth     = 4
) (
    input  logic clock,
    input  logic resetn,
    buff_uart_bus_master_if.master bus
`ifdef BUFF_UART_BUS_MASTER_STATS_EN
    ,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count
`endif
);
    localparam int PTR_W = $clog2(fifo_depth);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(fifo_depth);

    typedef enum logic [2:0] {
        S_IDLE, S_STAT_REQ, S_STAT_WAIT, S_RX_REQ, S_RX_WAIT, S_TX_PUSH
    } state_t;

    state_t state, next_state;

    logic [width-1:0]      mem [fifo_depth];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count, count_d;
    logic                  tx_ready_q, push, pop, fifo_empty;
    logic [addr_width-1:0] addr_q, addr_d;
    logic                  re_q, re_d, we_q, we_d, rxv_q, rxv_d;
    logic [width-1:0]      dout_q, dout_d, rx_hold;

    assign fifo_empty = (count == '0);
    assign push       = bus.tx_valid && tx_ready_q;
    // Pop at the decision edge so the head is loaded into bus_data_out for S_TX_PUSH.
    assign pop        = (state == S_STAT_WAIT) && (next_state == S_TX_PUSH);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE:      next_state = S_STAT_REQ;
            S_STAT_REQ:  next_state = S_STAT_WAIT;
            S_STAT_WAIT: begin
                if (bus.bus_data_in[0])                    next_state = S_RX_REQ;
                else if (bus.bus_data_in[1] && !fifo_empty) next_state = S_TX_PUSH;
                else                                        next_state = S_IDLE;
            end
            S_RX_REQ:    next_state = S_RX_WAIT;
            default:     next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from next_state and registered, so they line up with the state.
    always_comb begin
        addr_d = addr_q;
        dout_d = dout_q;
        re_d   = 1'b0;
        we_d   = 1'b0;
        rxv_d  = 1'b0;
        case (next_state)
            S_STAT_REQ: begin addr_d = addr_width'(status_address); we_d = 1'b1; end
            S_RX_REQ:   begin addr_d = addr_width'(rx_address);     we_d = 1'b1; end
            S_RX_WAIT:  rxv_d = 1'b1;
            S_TX_PUSH:  begin
                addr_d = addr_width'(tx_address);
                re_d   = 1'b1;
                dout_d = mem[rd_ptr];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= '0;
            dout_q  <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            rxv_q   <= 1'b0;
            rx_hold <= '0;
        end else begin
            addr_q <= addr_d;
            dout_q <= dout_d;
            re_q   <= re_d;
            we_q   <= we_d;
            rxv_q  <= rxv_d;
            if (state == S_RX_WAIT) rx_hold <= bus.bus_data_in;
        end
    end

    always_comb begin
        count_d = count;
        if (push && !pop)      count_d = count + (PTR_W+1)'(1);
        else if (pop && !push) count_d = count - (PTR_W+1)'(1);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            tx_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count      <= count_d;
            tx_ready_q <= (count_d != FULL_CNT);
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= bus.tx_data;
    end

    // Received byte is passed straight through in S_RX_WAIT, then held.
    assign bus.rx_data        = (state == S_RX_WAIT) ? bus.bus_data_in : rx_hold;
    assign bus.rx_valid       = rxv_q;
    assign bus.tx_ready       = tx_ready_q;
    assign bus.active_address = addr_q;
    assign bus.read_enable    = re_q;
    assign bus.write_enable   = we_q;
    assign bus.bus_data_out   = dout_q;

`ifdef BUFF_UART_BUS_MASTER_STATS_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tx_count <= 16'd0;
            rx_count <= 16'd0;
        end else begin
            if (state == S_TX_PUSH) tx_count <= tx_count + 16'd1;
            if (rxv_q)              rx_count <= rx_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_buff_uart_bus_master.sv
// Scoreboard bench for buff_uart_bus_master against a behavioural UART register model.
module tb_buff_uart_bus_master;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    buff_uart_bus_master_if #(.width(8), .addr_width(8)) bus ();

`ifdef BUFF_UART_BUS_MASTER_STATS_EN
    logic [15:0] tx_count, rx_count;
`endif

    buff_uart_bus_master #(
        .width(8), .addr_width(8), .rx_address(3), .tx_address(4),
        .status_address(5), .fifo_depth(4)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .bus(bus.master)
`ifdef BUFF_UART_BUS_MASTER_STATS_EN
        ,
        .tx_count(tx_count),
        .rx_count(rx_count)
`endif
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // UART register model
    logic       tx_free = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    int         rx_armed = 0;
    int         rx_reads = 0;

    always @(posedge clock) begin
        if (bus.write_enable) begin
            if (bus.active_address == 8'd5)
                bus.bus_data_in <= {6'b0, tx_free, (rx_reads < rx_armed)};
            else if (bus.active_address == 8'd3) begin
                bus.bus_data_in <= rx_byte;
                rx_reads <= rx_reads + 1;
            end else
                bus.bus_data_in <= 8'h00;
        end
    end

    typedef struct {
        bit         is_rx;
        logic [7:0] data;
    } ev_t;
    ev_t exp_q[$];
    int  tx_seen = 0;
    int  rx_seen = 0;

    // Monitor: every rx strobe or transmit push is matched against the queue in order.
    always @(negedge clock) begin
        if (resetn) begin
            if (bus.read_enable) check("re_we_exclusive", bus.write_enable, 0);
            if (bus.rx_valid || bus.read_enable) begin
                if (bus.read_enable) tx_seen++;
                if (bus.rx_valid)    rx_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {bus.rx_valid, bus.read_enable,
                          bus.rx_valid ? bus.rx_data : bus.bus_data_out}, 0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("event_kind", bus.rx_valid, e.is_rx);
                    if (bus.rx_valid) check("rx_data", bus.rx_data, e.data);
                    else begin
                        check("tx_data", bus.bus_data_out, e.data);
                        check("tx_address", bus.active_address, 4);
                    end
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, output logic accepted);
        @(negedge clock);
        accepted     = bus.tx_ready;
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        @(posedge clock);
        #1 bus.tx_valid = 1'b0;
    endtask

    task automatic expect_ev(input bit is_rx, input logic [7:0] d);
        ev_t e;
        e.is_rx = is_rx;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clock);
        #1 check(name, exp_q.size(), 0);
    endtask

    logic acc;
    int   tx_base, rx_base;
    bit   found;

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.bus_data_in = 8'h00;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_address", bus.active_address, 0);
        check("rst_read_enable", bus.read_enable, 0);
        check("rst_write_enable", bus.write_enable, 0);
        check("rst_bus_data_out", bus.bus_data_out, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_tx_ready", bus.tx_ready, 1);
`ifdef BUFF_UART_BUS_MASTER_STATS_EN
        check("rst_tx_count", tx_count, 0);
        check("rst_rx_count", rx_count, 0);
`endif
        resetn = 1'b1;
        #1 check("pre_poll_write_enable", bus.write_enable, 0);
        @(posedge clock);
        #1;
        check("first_poll_write_enable", bus.write_enable, 1);
        check("first_poll_address", bus.active_address, 5);

        // Single transmit
        tx_free = 1'b1;
        expect_ev(0, 8'h0A);
        push_byte(8'h0A, acc);
        check("single_accept", acc, 1);
        drain("single_drain");
        repeat (20) @(negedge clock);
        check("single_tx_ready", bus.tx_ready, 1);

        // FIFO full, then drain in order
        tx_free = 1'b0;
        repeat (5) @(negedge clock);
        for (int i = 1; i <= 4; i++) begin
            logic [7:0] b;
            b = 8'(i);
            push_byte(b, acc);
            check("fill_accept", acc, 1);
        end
        @(negedge clock);
        check("full_tx_ready", bus.tx_ready, 0);
        push_byte(8'h05, acc);
        check("full_reject", acc, 0);
        for (int i = 1; i <= 4; i++) expect_ev(0, 8'(i));
        tx_free = 1'b1;
        drain("fifo_drain");
        repeat (20) @(negedge clock);
        check("drained_tx_ready", bus.tx_ready, 1);

        // Receive has priority over a pending transmit
        tx_free = 1'b0;
        rx_byte = 8'h55;
        push_byte(8'h3E, acc);
        check("prio_accept", acc, 1);
        expect_ev(1, 8'h55);
        expect_ev(0, 8'h3E);
        @(negedge clock);
        tx_free  = 1'b1;
        rx_armed = rx_armed + 1;
        drain("prio_drain");
        rx_base = rx_seen;
        repeat (20) @(negedge clock);
        check("prio_single_rx", rx_seen - rx_base, 0);
`ifdef BUFF_UART_BUS_MASTER_STATS_EN
        check("stats_tx_count", tx_count, 6);
        check("stats_rx_count", rx_count, 1);
`endif

        // Reset in S_RX_WAIT with two bytes queued
        tx_free = 1'b0;
        repeat (5) @(negedge clock);
        push_byte(8'h11, acc);
        push_byte(8'h22, acc);
        rx_byte  = 8'hA7;
        rx_armed = rx_armed + 1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clock);
            if (bus.write_enable && bus.active_address == 8'd3) found = 1'b1;
        end
        check("midrst_rx_req_seen", found, 1);
        @(posedge clock);
        #1 resetn = 1'b0;
        tx_base = tx_seen;
        rx_base = rx_seen;
        @(negedge clock);
        check("midrst_rx_valid", bus.rx_valid, 0);
        check("midrst_tx_ready", bus.tx_ready, 1);
        check("midrst_read_enable", bus.read_enable, 0);
`ifdef BUFF_UART_BUS_MASTER_STATS_EN
        check("midrst_tx_count", tx_count, 0);
        check("midrst_rx_count", rx_count, 0);
`endif
        repeat (2) @(posedge clock);
        @(negedge clock);
        tx_free = 1'b1;
        resetn  = 1'b1;
        repeat (40) @(negedge clock);
        #1;
        check("midrst_no_push", tx_seen - tx_base, 0);
        check("midrst_no_rx", rx_seen - rx_base, 0);
        check("midrst_tx_ready_after", bus.tx_ready, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
